// File: rtl/exe_mem_skid_reg.sv
// Execute-to-memory boundary register with a 2-entry skid buffer and the NZCV status register.
// Optional EXE_STALL_CNT_EN macro adds a saturating 32-bit input-stall counter output (stall_cnt).
module exe_mem_skid_reg #(
  parameter int DATA_LEN     = 32,
  parameter int REG_ADDR_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_LEN-1:0]     alu_res,
  input  logic [DATA_LEN-1:0]     val_rm,
  input  logic [REG_ADDR_LEN-1:0] dest,
  input  logic                    wb_en,
  input  logic                    mem_r_en,
  input  logic                    mem_w_en,
  input  logic                    s_en,
  input  logic                    flag_n,
  input  logic                    flag_z,
  input  logic                    flag_c,
  input  logic                    flag_v,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_LEN-1:0]     out_alu_res,
  output logic [DATA_LEN-1:0]     out_val_rm,
  output logic [REG_ADDR_LEN-1:0] out_dest,
  output logic                    out_wb_en,
  output logic                    out_mem_r_en,
  output logic                    out_mem_w_en,
`ifdef EXE_STALL_CNT_EN
  output logic [31:0]             stall_cnt,
`endif
  output logic [3:0]              status,
  output logic                    carry_to_alu
);

  typedef struct packed {
    logic [DATA_LEN-1:0]     alu_res;
    logic [DATA_LEN-1:0]     val_rm;
    logic [REG_ADDR_LEN-1:0] dest;
    logic                    wb_en;
    logic                    mem_r_en;
    logic                    mem_w_en;
  } entry_t;

  entry_t     main_q, main_d, skid_q, skid_d, in_entry;
  logic       main_valid_q, main_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic [3:0] status_q, status_d;
  logic       accept, drain;

  assign in_entry = '{alu_res: alu_res, val_rm: val_rm, dest: dest,
                      wb_en: wb_en, mem_r_en: mem_r_en, mem_w_en: mem_w_en};

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready & ~flush;
  assign drain    = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    status_d     = status_q;
    if (accept && s_en) status_d = {flag_n, flag_z, flag_c, flag_v};
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || (drain && !skid_valid_q)) begin
      main_valid_d = accept;
      if (accept) main_d = in_entry;
    end else if (drain) begin
      // Skid is full here, so in_ready was low and nothing new can arrive.
      main_d       = skid_q;
      main_valid_d = 1'b1;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      status_q     <= 4'b0000;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      status_q     <= status_d;
    end
  end

`ifdef EXE_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign out_valid    = main_valid_q;
  assign out_alu_res  = main_q.alu_res;
  assign out_val_rm   = main_q.val_rm;
  assign out_dest     = main_q.dest;
  // Enables are qualified so an empty slot never issues a phantom access.
  assign out_wb_en    = main_q.wb_en    & main_valid_q;
  assign out_mem_r_en = main_q.mem_r_en & main_valid_q;
  assign out_mem_w_en = main_q.mem_w_en & main_valid_q;
  assign status       = status_q;
  assign carry_to_alu = status_q[1];

endmodule
